// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency meter gate controller.
package freq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StSettle,
        StLatch,
        StHold
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX     = 4'd9;
    localparam logic RANGE_LONG  = 1'b0;
    localparam logic RANGE_SHORT = 1'b1;

    function automatic logic bcd_all_max(input bcd_t th, input bcd_t hu,
                                         input bcd_t te, input bcd_t on);
        return (th == BCD_MAX) && (hu == BCD_MAX) && (te == BCD_MAX) && (on == BCD_MAX);
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_ms_tick.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 clocks, synchronously restartable.
module ms_tick #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned Period = CLK_HZ / 1000;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntW'(Period - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-timing controller and result latch for the BCD event counter.
// Defining FREQ_AUTORANGE_EN replaces range_sel with automatic range selection.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned GATE_LONG_MS  = 1000,
    parameter int unsigned GATE_SHORT_MS = 100,
    parameter int unsigned HOLD_MS       = 500,
    parameter int unsigned CLEAR_CYC     = 4,
    parameter int unsigned SETTLE_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       range_sel,
    input  logic [3:0] thousand_in,
    input  logic [3:0] hundred_in,
    input  logic [3:0] ten_in,
    input  logic [3:0] one_in,
    output logic       en,
    output logic       zero,
    output logic [3:0] disp_thousand,
    output logic [3:0] disp_hundred,
    output logic [3:0] disp_ten,
    output logic [3:0] disp_one,
    output logic       disp_range,
    output logic       over,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned MsMax0 = (GATE_LONG_MS > GATE_SHORT_MS) ? GATE_LONG_MS : GATE_SHORT_MS;
    localparam int unsigned MsMax  = (MsMax0 > HOLD_MS) ? MsMax0 : HOLD_MS;
    localparam int unsigned MsW    = $clog2(MsMax + 1);
    localparam int unsigned CycMax = (CLEAR_CYC > SETTLE_CYC) ? CLEAR_CYC : SETTLE_CYC;
    localparam int unsigned CycW   = $clog2(CycMax + 1);

    state_e          state_q, state_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [MsW-1:0]  ms_q, ms_d;
    logic [MsW-1:0]  gate_last;
    logic            range_q;
    logic            rng_sample;
    logic            tick;
    logic            restart;
    logic            sat;
    logic            clear_entry;

    logic       en_q, zero_q, busy_q, valid_q, over_q, disp_range_q;
    bcd_t       disp_th_q, disp_hu_q, disp_te_q, disp_on_q;

    ms_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Prescaler is held cleared outside the ms-timed states, so it restarts on entry.
    assign restart     = (state_q != StGate) && (state_q != StHold);
    assign sat         = bcd_all_max(thousand_in, hundred_in, ten_in, one_in);
    assign gate_last   = (range_q == RANGE_SHORT) ? MsW'(GATE_SHORT_MS - 1)
                                                  : MsW'(GATE_LONG_MS - 1);
    assign clear_entry = (state_q != StClear) && (state_d == StClear);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ms_d    = ms_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StClear;
            end
            StClear: begin
                if (cyc_q == CycW'(CLEAR_CYC - 1)) state_d = StGate;
                else cyc_d = cyc_q + 1'b1;
            end
            StGate: begin
                if (tick) begin
                    if (ms_q == gate_last) state_d = StSettle;
                    else ms_d = ms_q + 1'b1;
                end
            end
            StSettle: begin
                if (cyc_q == CycW'(SETTLE_CYC - 1)) state_d = StLatch;
                else cyc_d = cyc_q + 1'b1;
            end
            StLatch: begin
                state_d = StHold;
            end
            StHold: begin
                if (tick) begin
                    if (ms_q == MsW'(HOLD_MS - 1)) state_d = run ? StClear : StIdle;
                    else ms_d = ms_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d != state_q) begin
            cyc_d = '0;
            ms_d  = '0;
        end
    end

`ifdef FREQ_AUTORANGE_EN
    logic auto_rng_q, auto_rng_d;
    logic unused_range_sel;

    assign unused_range_sel = range_sel;
    assign rng_sample       = auto_rng_q;

    always_comb begin
        auto_rng_d = auto_rng_q;
        if (state_q == StLatch) begin
            if ((range_q == RANGE_LONG) && sat) begin
                auto_rng_d = RANGE_SHORT;
            end else if ((range_q == RANGE_SHORT) && (thousand_in == 4'd0) &&
                         (hundred_in < BCD_MAX)) begin
                auto_rng_d = RANGE_LONG;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_rng_q <= RANGE_LONG;
        end else begin
            auto_rng_q <= auto_rng_d;
        end
    end
`else
    assign rng_sample = range_sel;
`endif

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            ms_q         <= '0;
            range_q      <= RANGE_LONG;
            en_q         <= 1'b0;
            zero_q       <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            over_q       <= 1'b0;
            disp_range_q <= 1'b0;
            disp_th_q    <= '0;
            disp_hu_q    <= '0;
            disp_te_q    <= '0;
            disp_on_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ms_q    <= ms_d;
            en_q    <= (state_d == StGate);
            zero_q  <= (state_d != StClear);
            busy_q  <= (state_d != StIdle);
            valid_q <= (state_q == StLatch);
            if (clear_entry) begin
                range_q <= rng_sample;
            end
            if (state_q == StLatch) begin
                disp_th_q    <= thousand_in;
                disp_hu_q    <= hundred_in;
                disp_te_q    <= ten_in;
                disp_on_q    <= one_in;
                disp_range_q <= range_q;
                over_q       <= sat;
            end
        end
    end

    assign en            = en_q;
    assign zero          = zero_q;
    assign busy          = busy_q;
    assign valid         = valid_q;
    assign over          = over_q;
    assign disp_range    = disp_range_q;
    assign disp_thousand = disp_th_q;
    assign disp_hundred  = disp_hu_q;
    assign disp_ten      = disp_te_q;
    assign disp_one      = disp_on_q;

endmodule

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Gate-timing controller and result latch for the frequency meter. It sits directly upstream of the 4-digit BCD event counter, driving its `en` (gate window) and `zero` (active-low clear) inputs. After each gate window it captures the counter's four BCD digits into stable display registers. It runs on the system clock and loops measure/hold cycles while `run` is high.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency
- `GATE_LONG_MS`, 1000, gate length for range 0 (1 Hz resolution)
- `GATE_SHORT_MS`, 100, gate length for range 1 (10 Hz resolution)
- `HOLD_MS`, 500, display hold time between measurements
- `CLEAR_CYC`, 4, cycles `zero` is held low before each gate
- `SETTLE_CYC`, 4, cycles after gate close before latching (counter ripple settle)
- `clk` in 1: system clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `run` in 1: 1 = measure continuously; 0 = stop after the current cycle.
- `range_sel` in 1: 0 = long gate, 1 = short gate; sampled on CLEAR entry only.
- `thousand_in`, `hundred_in`, `ten_in`, `one_in` in 4 each: BCD digits from the counter.
- `en` out 1: counter enable (gate window).
- `zero` out 1: counter clear, active-low.
- `disp_thousand`, `disp_hundred`, `disp_ten`, `disp_one` out 4 each: latched result.
- `disp_range` out 1: range used for the latched result.
- `over` out 1: latched result is 9999, i.e. the counter saturated.
- `valid` out 1: one-cycle pulse when new result is latched.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD. All outputs are registered.
- IDLE: `en`=0, `zero`=1. If `run`=1, go to CLEAR and sample the range.
- CLEAR: `zero`=0 for CLEAR_CYC cycles, then go to GATE.
- GATE: `en`=1 for exactly GATE_x_MS·CLK_HZ/1000 cycles, then go to SETTLE.
- SETTLE: `en`=0, `zero`=1 for SETTLE_CYC cycles, then go to LATCH.
- LATCH (1 cycle): capture the four input digits and the range; set `over` = (digits == 9,9,9,9); pulse `valid`. Go to HOLD.
- HOLD: wait HOLD_MS. Then go to CLEAR if `run`=1, else IDLE.
- `run` falling mid-cycle never aborts a measurement. The current result is always latched.
- Input digits are asynchronous to `clk` but are only sampled while `en`=0 after SETTLE, when they are static. No synchronizer is required.
- Reset values: `en`=0, `zero`=0 (counter is held clear during reset), disp_* = 0, `disp_range`=0, `over`=0, `valid`=0, `busy`=0, state = IDLE.
- Reset asserted mid-operation: takes effect at the next edge. The window is aborted and the display is cleared.

## Timing
- `run`=1 sampled in IDLE at edge N gives this sequence:
  - `zero`=0 for edges N+1 … N+CLEAR_CYC.
  - `en`=1 for the following G cycles.
  - SETTLE_CYC cycles of settle.
  - LATCH.
  - New disp_*, `over` and `valid`=1 visible for one cycle at edge N+CLEAR_CYC+G+SETTLE_CYC+2.
- HOLD lasts exactly HOLD_MS·CLK_HZ/1000 cycles. With `run` still high, CLEAR follows with no idle cycle.
- Gate length is exact to the cycle. The ms prescaler restarts on GATE and HOLD entry.

## Configuration
- `FREQ_AUTORANGE_EN` defined: `range_sel` is ignored and range is chosen automatically.
  - After reset the range is 0.
  - If a range-0 result has `over`=1, the next measurement uses range 1.
  - If a range-1 result has `disp_thousand`=0 and `disp_hundred`<9, the next measurement uses range 0.
  - Otherwise the range is unchanged.
- `FREQ_AUTORANGE_EN` undefined: range comes from `range_sel` only.

## Structure
- Package `freq_pkg` holds:
  - the FSM state enum;
  - the 4-bit BCD digit typedef;
  - constant `BCD_MAX` = 4'd9;
  - range encoding constants.
- Sub-module `ms_tick`: synchronous `restart` input; one-cycle pulse every CLK_HZ/1000 cycles. GATE and HOLD count its ticks.
- CLEAR and SETTLE use a small cycle counter in the top level.

## Test plan
Bench parameters: CLK_HZ=10000, GATE_LONG_MS=10, GATE_SHORT_MS=1, HOLD_MS=2, CLEAR_CYC=4, SETTLE_CYC=4.
- Reset: `rst` high 3 cycles → `en`=0, `zero`=0, disp_*=0, `busy`=0. Release with `run`=0 → `zero`=1, `en`=0.
- Long gate: `run`=1 at edge 0, `range_sel`=0, digits 1,2,3,4 → `zero` low for edges 1–4, `en` high for exactly 100 cycles, `valid` at edge 110, disp=1234, `over`=0, `disp_range`=0.
- Saturation: digits 9,9,9,9, `range_sel`=1 → `en` high for 10 cycles, `over`=1, `disp_range`=1.
- `run` dropped mid-GATE → result still latched with `valid`, 20 HOLD cycles, then IDLE with `busy`=0.
- `rst` at gate cycle 50 → next edge `en`=0, `zero`=0, disp_*=0, no `valid`.
- With `FREQ_AUTORANGE_EN`: range-0 result 9999 → next gate 10 cycles, `disp_range`=1. A following result of 0850 → next gate 100 cycles.
